// File: rtl/dc_fu_pixel_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : dc_fu_pixel_fifo_if
// Brief    : AXI read-data snoop and pixel-stream bundle for dc_fu_pixel_fifo.
//            PIX_W defaults to 24 when DC_FU_PIXEL_RGB888_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface dc_fu_pixel_fifo_if #(
    parameter int DATA_WIDTH = 16,
`ifdef DC_FU_PIXEL_RGB888_EN
    parameter int PIX_W      = 24
`else
    parameter int PIX_W      = 16
`endif
);
    logic [DATA_WIDTH-1:0] axi_rdata;
    logic                  axi_rvalid;
    logic                  axi_rready;
    logic [PIX_W-1:0]      pix_data;
    logic                  pix_valid;
    logic                  pix_ready;

    // master: DMA/scaler side; slave: the FIFO
    modport master (
        output axi_rdata, axi_rvalid, axi_rready, pix_ready,
        input  pix_data, pix_valid
    );
    modport slave (
        input  axi_rdata, axi_rvalid, axi_rready, pix_ready,
        output pix_data, pix_valid
    );
endinterface
`default_nettype wire

// File: rtl/dc_fu_pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dc_fu_pixel_fifo
// Brief    : Snoops accepted AXI read beats into a show-ahead FIFO feeding the
//            scaler. Optional RGB565->RGB888 read-path expansion via macro
//            DC_FU_PIXEL_RGB888_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dc_fu_pixel_fifo #(
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH_LOG2    = 6,
    parameter int MAX_BURST_LEN = 4
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                en,
    input  logic                flush,
    dc_fu_pixel_fifo_if.slave   bus,
    output logic [DEPTH_LOG2:0] level,
    output logic                empty,
    output logic                burst_space,
    output logic                overflow
);
    localparam int                c_DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_DEPTH_W = (DEPTH_LOG2 + 1)'(c_DEPTH);
    localparam logic [DEPTH_LOG2:0] c_BURST   = (DEPTH_LOG2 + 1)'(2 ** MAX_BURST_LEN);

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_overflow;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_wr_ok;
    logic                  w_drop;
    logic [DEPTH_LOG2:0]   w_free;
    logic [DATA_WIDTH-1:0] w_head;

    assign w_push  = en && bus.axi_rvalid && bus.axi_rready;
    assign w_pop   = en && bus.pix_valid && bus.pix_ready;
    assign w_full  = (r_level == c_DEPTH_W);
    // A pop in the same cycle frees the slot, so push-at-full is lossless then
    assign w_wr_ok = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr_ok && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_wr_ok) begin
                r_level <= r_level - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok && !flush) begin
            r_mem[r_wr_ptr] <= bus.axi_rdata;
        end
    end

    assign w_head        = r_mem[r_rd_ptr];
    assign w_free        = c_DEPTH_W - r_level;
    assign bus.pix_valid = en && (r_level != '0);
    assign level         = r_level;
    assign empty         = (r_level == '0);
    assign burst_space   = (w_free >= c_BURST);
    assign overflow      = r_overflow;

`ifdef DC_FU_PIXEL_RGB888_EN
    // Replicate MSBs into the low bits so full-scale 565 maps to full-scale 888
    assign bus.pix_data = {w_head[15:11], w_head[15:13],
                           w_head[10:5],  w_head[10:9],
                           w_head[4:0],   w_head[4:2]};
`else
    assign bus.pix_data = w_head;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dc_fu_pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_dc_fu_pixel_fifo
// Brief    : Self-checking bench for dc_fu_pixel_fifo against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dc_fu_pixel_fifo;
`ifdef DC_FU_PIXEL_RGB888_EN
    localparam int c_PIX_W = 24;
`else
    localparam int c_PIX_W = 16;
`endif
    localparam int c_DEPTH = 64;
    localparam int c_BURST = 16;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       en = 1'b0;
    logic       flush = 1'b0;
    logic [6:0] level;
    logic       empty;
    logic       burst_space;
    logic       overflow;

    int n_checks = 0;
    int n_err    = 0;

    logic [15:0] q[$];
    logic        m_ovf = 1'b0;

    dc_fu_pixel_fifo_if #(.DATA_WIDTH(16), .PIX_W(c_PIX_W)) bus_if ();

    dc_fu_pixel_fifo #(
        .DATA_WIDTH   (16),
        .DEPTH_LOG2   (6),
        .MAX_BURST_LEN(4)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .en         (en),
        .flush      (flush),
        .bus        (bus_if),
        .level      (level),
        .empty      (empty),
        .burst_space(burst_space),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_pix(input logic [15:0] w);
`ifdef DC_FU_PIXEL_RGB888_EN
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
        r5 = w[15:11];
        g6 = w[10:5];
        b5 = w[4:0];
        return {8'h00, r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
`else
        return {16'h0000, w};
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ph);
        int sz;
        sz = q.size();
        chk({ph, ".level"}, 32'(level), 32'(sz));
        chk({ph, ".empty"}, 32'(empty), 32'(sz == 0));
        chk({ph, ".burst_space"}, 32'(burst_space), 32'((c_DEPTH - sz) >= c_BURST));
        chk({ph, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({ph, ".pix_valid"}, 32'(bus_if.pix_valid), 32'(en && nrst && sz != 0));
        if (en && sz != 0)
            chk({ph, ".pix_data"}, 32'(bus_if.pix_data), exp_pix(q[0]));
    endtask

    // Advance one clock edge and apply the behavioural rules to the model
    task automatic cyc();
        logic push, pop;
        @(posedge clk);
        if (!nrst) begin
            q.delete();
            m_ovf = 1'b0;
        end else if (flush) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            pop  = en && bus_if.pix_ready && (q.size() != 0);
            push = en && bus_if.axi_rvalid && bus_if.axi_rready;
            if (pop) void'(q.pop_front());
            if (push) begin
                if (q.size() < c_DEPTH) q.push_back(bus_if.axi_rdata);
                else m_ovf = 1'b1;
            end
        end
        #1;
    endtask

    task automatic step(input logic e, input logic f, input logic v, input logic r,
                        input logic [15:0] d, input logic p, input string ph);
        en                = e;
        flush             = f;
        bus_if.axi_rvalid = v;
        bus_if.axi_rready = r;
        bus_if.axi_rdata  = d;
        bus_if.pix_ready  = p;
        #1;
        check_outputs(ph);
        cyc();
    endtask

    initial begin
        bus_if.axi_rdata  = '0;
        bus_if.axi_rvalid = 1'b0;
        bus_if.axi_rready = 1'b0;
        bus_if.pix_ready  = 1'b0;
        en                = 1'b1;
        repeat (2) cyc();
        check_outputs("reset");
        chk("reset.burst_space_const", 32'(burst_space), 32'd1);
        nrst = 1'b1;

        // Basic flow
        for (int i = 0; i < 16; i++) step(1, 0, 1, 1, 16'(i), 1, "basic");
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 16'h0, 1, "basic_tail");
        chk("basic.level0", 32'(level), 32'd0);
        chk("basic.empty1", 32'(empty), 32'd1);

        // Fill to full under backpressure, then overflow
        for (int i = 0; i < 64; i++) step(1, 0, 1, 1, 16'(i), 0, "fill");
        chk("full.level", 32'(level), 32'd64);
        chk("full.burst_space", 32'(burst_space), 32'd0);
        chk("full.overflow", 32'(overflow), 32'd0);
        step(1, 0, 1, 1, 16'h0040, 0, "over");
        chk("over.overflow", 32'(overflow), 32'd1);
        chk("over.level", 32'(level), 32'd64);
        chk("over.head", 32'(bus_if.pix_data), exp_pix(16'h0000));
        for (int i = 0; i < 64; i++) step(1, 0, 0, 0, 16'h0, 1, "drain");
        chk("drain.empty", 32'(empty), 32'd1);

        // Simultaneous push/pop at full
        step(1, 1, 0, 0, 16'h0, 0, "flush0");
        for (int i = 0; i < 64; i++) step(1, 0, 1, 1, 16'(16'h100 + i), 0, "refill");
        step(1, 0, 1, 1, 16'hABCD, 1, "pushpop");
        chk("pushpop.level", 32'(level), 32'd64);
        chk("pushpop.overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 64; i++) step(1, 0, 0, 0, 16'h0, 1, "drain2");

        // burst_space threshold
        for (int i = 0; i < 48; i++) step(1, 0, 1, 1, 16'($urandom), 0, "thr_fill");
        chk("thr48.burst_space", 32'(burst_space), 32'd1);
        step(1, 0, 1, 1, 16'h1234, 0, "thr49");
        chk("thr49.burst_space", 32'(burst_space), 32'd0);
        step(1, 0, 0, 0, 16'h0, 1, "thr_pop");
        chk("thr48b.burst_space", 32'(burst_space), 32'd1);

        // flush with coinciding push while overflowed at level 20
        for (int i = 0; i < 17; i++) step(1, 0, 1, 1, 16'($urandom), 0, "ovf_fill");
        step(1, 0, 1, 1, 16'hDEAD, 0, "ovf_drop");
        for (int i = 0; i < 44; i++) step(1, 0, 0, 0, 16'h0, 1, "to20");
        chk("pre_flush.level", 32'(level), 32'd20);
        chk("pre_flush.overflow", 32'(overflow), 32'd1);
        step(1, 1, 1, 1, 16'hBEEF, 0, "flush_push");
        chk("flush.level", 32'(level), 32'd0);
        chk("flush.overflow", 32'(overflow), 32'd0);
        chk("flush.empty", 32'(empty), 32'd1);

        // en low freezes everything
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 16'(16'h500 + i), 0, "pre_en");
        for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 16'(16'h600 + i), 1, "en_low");
        chk("en_low.level", 32'(level), 32'd3);
        chk("en_low.pix_valid", 32'(bus_if.pix_valid), 32'd0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 16'h0, 1, "en_back");

        // Randomized traffic with alternating fill/drain bias
        for (int i = 0; i < 2000; i++) begin
            logic pr;
            if (((i / 250) % 2) == 0) pr = ($urandom_range(3) == 0);
            else                      pr = ($urandom_range(3) != 0);
            step(($urandom_range(7) != 0), ($urandom_range(299) == 0),
                 1'($urandom), ($urandom_range(3) != 0), 16'($urandom), pr, "rand");
        end

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) step(1, 0, 1, 1, 16'(16'h700 + i), 0, "pre_rst");
        #2;
        nrst = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        check_outputs("async_rst");
        cyc();
        nrst = 1'b1;
        step(1, 0, 0, 0, 16'h0, 1, "post_rst");

`ifdef DC_FU_PIXEL_RGB888_EN
        begin
            logic [15:0] c_in  [4];
            logic [23:0] c_out [4];
            c_in  = '{16'hF800, 16'h07E0, 16'h001F, 16'h8410};
            c_out = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h848284};
            for (int i = 0; i < 4; i++) begin
                step(1, 0, 1, 1, c_in[i], 0, "rgb_push");
                chk("rgb.pix_data", 32'(bus_if.pix_data), {8'h00, c_out[i]});
                step(1, 0, 0, 0, 16'h0, 1, "rgb_pop");
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
